ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage
Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width, matching the 32-bit ALU.
REQ-002 SHALL have port Clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ID_Rs_Data  in  DATA_W  register-file read of rs.
REQ-005 SHALL have port ID_Rt_Data  in  DATA_W  register-file read of rt.
REQ-006 SHALL have port ID_Imm  in  DATA_W  already-extended immediate.
REQ-007 SHALL have port ID_Rs  in  5  rs index.
REQ-008 SHALL have port ID_Rt  in  5  rt index.
REQ-009 SHALL have port ID_Rd  in  5  destination index chosen by decode.
REQ-010 SHALL have port ID_Select  in  4  ALU operation code, passed opaque.
REQ-011 SHALL have port ID_Cin  in  1  ALU carry-in (1 for subtract/compare).
REQ-012 SHALL have port ID_Use_Imm  in  1  B operand is immediate.
REQ-013 SHALL have port ID_Reg_Write  in  1  instruction writes Rd.
REQ-014 SHALL have port ID_Mem_Read  in  1  instruction is a load.
REQ-015 SHALL have port Stall  in  1  downstream hold; freeze stage.
REQ-016 SHALL have port Flush  in  1  squash instruction being captured (branch/jump).
REQ-017 SHALL have port MEM_Reg_Write / MEM_Rd / MEM_Result  in  1/5/DATA_W  EX/MEM writeback candidate.
REQ-018 SHALL have port WB_Reg_Write / WB_Rd / WB_Result  in  1/5/DATA_W  MEM/WB writeback candidate.
REQ-019 SHALL have port ALU_A  out  DATA_W  ALU A operand (to ALU_32b A).
REQ-020 SHALL have port ALU_B  out  DATA_W  ALU B operand (to ALU_32b B).
REQ-021 SHALL have port ALU_Select / ALU_Cin  out  4/1  registered ID_Select / ID_Cin.
REQ-022 SHALL have port Store_Data  out  DATA_W  forwarded rt value for stores.
REQ-023 SHALL have port EX_Rd / EX_Reg_Write / EX_Mem_Read  out  5/1/1  registered controls to EX/MEM.
REQ-024 SHALL have port Load_Use  out  1  load-use hazard; upstream must hold PC and IF/ID.
Function
REQ-025 SHALL register all ID_* inputs each edge; capture priority: Flush > Stall > Load_Use > normal load.
REQ-026 Flush or Load_Use (without Stall) SHALL load a bubble: all registered fields zero, Reg_Write=0, Mem_Read=0; Flush with Stall together SHALL still bubble.
REQ-027 Stall alone SHALL hold every register unchanged; forwarding outputs keep following live MEM/WB inputs.
REQ-028 Forward-A SHALL select MEM_Result if MEM_Reg_Write, MEM_Rd!=0, MEM_Rd==reg Rs; else WB_Result under same rule with WB; else registered Rs data.
REQ-029 Forward-B (Store_Data) SHALL apply REQ-028 rule to registered Rt; EX/MEM wins when both match.
REQ-030 ALU_B SHALL equal registered Imm when registered Use_Imm=1, else Store_Data.
REQ-031 Forwarding muxes SHALL be combinational after the register: zero added latency, one-cycle stage latency ID to ALU.
REQ-032 Load_Use SHALL be combinational: EX_Mem_Read & EX_Rd!=0 & (EX_Rd==ID_Rs | EX_Rd==ID_Rt); never asserted on a bubble.
REQ-033 Register index 0 SHALL never match for forwarding or hazard.
Reset
REQ-034 Rst SHALL immediately clear all registers to bubble state; all outputs 0 (ALU_A/B then reflect zeroed data with no forwarding), Load_Use 0; mid-operation reset discards the held instruction.
Structure
REQ-035 Bubble constant, reg-index width (5) and DATA_W SHALL live in the shared CPU package; forwarding mux SHALL be one sub-module, fwd_mux, instantiated twice (A and B).
Verification
REQ-036 ID_Rs=3, data 0x10, MEM_Reg_Write=1, MEM_Rd=3, MEM_Result=0x55, WB_Rd=3 WB_Result=0x66 -> next cycle ALU_A=0x55.
REQ-037 Load to Rd=4 captured, next ID_Rt=4 -> Load_Use=1 for one cycle, following cycle EX_Reg_Write=0, EX_Rd=0.
REQ-038 ID_Use_Imm=1, ID_Imm=0xFFFFFFFC, ID_Rt fwd match -> ALU_B=0xFFFFFFFC, Store_Data=forwarded value.
REQ-039 Stall=1 for 3 cycles with changing ID inputs -> ALU_Select/EX_Rd unchanged; Stall+Flush -> bubble.
REQ-040 Rst pulse mid-cycle with valid instruction held -> outputs 0 immediately; MEM_Rd=0 match never forwards.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_pkg
// Brief    : Shared CPU widths, ID/EX control record and its bubble value.
// Revision : 1.0
// ============================================================================
package ex_operand_stage_pkg;

    localparam int c_data_w = 32;
    localparam int c_reg_w  = 5;

    typedef logic [c_reg_w-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t   rs;
        reg_idx_t   rt;
        reg_idx_t   rd;
        logic [3:0] alu_sel;
        logic       cin;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
    } ex_ctrl_t;

    // A bubble is an all-zero record: no write, no load, rd/rs/rt all r0.
    localparam ex_ctrl_t c_ctrl_bubble = '0;

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Brief    : Operand bypass select: EX/MEM result, then MEM/WB, then reg file.
// Revision : 1.0
// ============================================================================
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic [c_reg_w-1:0] i_src_idx,
    input  logic [DATA_W-1:0]  i_src_data,
    input  logic               i_mem_wr,
    input  logic [c_reg_w-1:0] i_mem_rd,
    input  logic [DATA_W-1:0]  i_mem_data,
    input  logic               i_wb_wr,
    input  logic [c_reg_w-1:0] i_wb_rd,
    input  logic [DATA_W-1:0]  i_wb_data,
    output logic [DATA_W-1:0]  o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    // r0 is hardwired zero, so a write targeting it must never be bypassed.
    assign w_mem_hit = i_mem_wr && (i_mem_rd != '0) && (i_mem_rd == i_src_idx);
    assign w_wb_hit  = i_wb_wr  && (i_wb_rd  != '0) && (i_wb_rd  == i_src_idx);

    always_comb begin
        o_data = i_src_data;
        if (w_mem_hit) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Brief    : ID/EX pipeline register with operand forwarding and load-use detect.
// Revision : 1.0
// ============================================================================
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [DATA_W-1:0]  ID_Rs_Data,
    input  logic [DATA_W-1:0]  ID_Rt_Data,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [c_reg_w-1:0] ID_Rs,
    input  logic [c_reg_w-1:0] ID_Rt,
    input  logic [c_reg_w-1:0] ID_Rd,
    input  logic [3:0]         ID_Select,
    input  logic               ID_Cin,
    input  logic               ID_Use_Imm,
    input  logic               ID_Reg_Write,
    input  logic               ID_Mem_Read,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               MEM_Reg_Write,
    input  logic [c_reg_w-1:0] MEM_Rd,
    input  logic [DATA_W-1:0]  MEM_Result,
    input  logic               WB_Reg_Write,
    input  logic [c_reg_w-1:0] WB_Rd,
    input  logic [DATA_W-1:0]  WB_Result,
    output logic [DATA_W-1:0]  ALU_A,
    output logic [DATA_W-1:0]  ALU_B,
    output logic [3:0]         ALU_Select,
    output logic               ALU_Cin,
    output logic [DATA_W-1:0]  Store_Data,
    output logic [c_reg_w-1:0] EX_Rd,
    output logic               EX_Reg_Write,
    output logic               EX_Mem_Read,
    output logic               Load_Use
);

    ex_ctrl_t          r_ctrl;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;

    ex_ctrl_t          w_id_ctrl;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    assign w_id_ctrl = '{rs: ID_Rs, rt: ID_Rt, rd: ID_Rd, alu_sel: ID_Select,
                         cin: ID_Cin, use_imm: ID_Use_Imm,
                         reg_write: ID_Reg_Write, mem_read: ID_Mem_Read};

    // A bubble in EX has mem_read=0, so the hazard cannot re-fire on itself.
    assign Load_Use = r_ctrl.mem_read && (r_ctrl.rd != '0) &&
                      ((r_ctrl.rd == ID_Rs) || (r_ctrl.rd == ID_Rt));

    // Flush beats Stall; a load-use bubble only goes in when not stalled.
    assign w_bubble = Flush || (!Stall && Load_Use);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ctrl    <= c_ctrl_bubble;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else if (w_bubble) begin
            r_ctrl    <= c_ctrl_bubble;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else if (!Stall) begin
            r_ctrl    <= w_id_ctrl;
            r_rs_data <= ID_Rs_Data;
            r_rt_data <= ID_Rt_Data;
            r_imm     <= ID_Imm;
        end
    end

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
        .i_src_idx  (r_ctrl.rs),
        .i_src_data (r_rs_data),
        .i_mem_wr   (MEM_Reg_Write),
        .i_mem_rd   (MEM_Rd),
        .i_mem_data (MEM_Result),
        .i_wb_wr    (WB_Reg_Write),
        .i_wb_rd    (WB_Rd),
        .i_wb_data  (WB_Result),
        .o_data     (w_fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
        .i_src_idx  (r_ctrl.rt),
        .i_src_data (r_rt_data),
        .i_mem_wr   (MEM_Reg_Write),
        .i_mem_rd   (MEM_Rd),
        .i_mem_data (MEM_Result),
        .i_wb_wr    (WB_Reg_Write),
        .i_wb_rd    (WB_Rd),
        .i_wb_data  (WB_Result),
        .o_data     (w_fwd_b)
    );

    assign ALU_A        = w_fwd_a;
    assign Store_Data   = w_fwd_b;
    assign ALU_B        = r_ctrl.use_imm ? r_imm : w_fwd_b;
    assign ALU_Select   = r_ctrl.alu_sel;
    assign ALU_Cin      = r_ctrl.cin;
    assign EX_Rd        = r_ctrl.rd;
    assign EX_Reg_Write = r_ctrl.reg_write;
    assign EX_Mem_Read  = r_ctrl.mem_read;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Brief    : Directed scoreboard bench for ex_operand_stage.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ex_operand_stage;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] alu_a;
        logic [DW-1:0] alu_b;
        logic [DW-1:0] store;
        logic [3:0]    sel;
        logic          cin;
        logic [4:0]    rd;
        logic          rw;
        logic          mr;
    } exp_t;

    logic          Clk;
    logic          Rst;
    logic [DW-1:0] ID_Rs_Data, ID_Rt_Data, ID_Imm;
    logic [4:0]    ID_Rs, ID_Rt, ID_Rd;
    logic [3:0]    ID_Select;
    logic          ID_Cin, ID_Use_Imm, ID_Reg_Write, ID_Mem_Read;
    logic          Stall, Flush;
    logic          MEM_Reg_Write, WB_Reg_Write;
    logic [4:0]    MEM_Rd, WB_Rd;
    logic [DW-1:0] MEM_Result, WB_Result;
    logic [DW-1:0] ALU_A, ALU_B, Store_Data;
    logic [3:0]    ALU_Select;
    logic          ALU_Cin;
    logic [4:0]    EX_Rd;
    logic          EX_Reg_Write, EX_Mem_Read, Load_Use;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ex_operand_stage #(.DATA_W(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_Rs_Data(ID_Rs_Data), .ID_Rt_Data(ID_Rt_Data), .ID_Imm(ID_Imm),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_Select(ID_Select), .ID_Cin(ID_Cin), .ID_Use_Imm(ID_Use_Imm),
        .ID_Reg_Write(ID_Reg_Write), .ID_Mem_Read(ID_Mem_Read),
        .Stall(Stall), .Flush(Flush),
        .MEM_Reg_Write(MEM_Reg_Write), .MEM_Rd(MEM_Rd), .MEM_Result(MEM_Result),
        .WB_Reg_Write(WB_Reg_Write), .WB_Rd(WB_Rd), .WB_Result(WB_Result),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Select(ALU_Select), .ALU_Cin(ALU_Cin),
        .Store_Data(Store_Data), .EX_Rd(EX_Rd), .EX_Reg_Write(EX_Reg_Write),
        .EX_Mem_Read(EX_Mem_Read), .Load_Use(Load_Use)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] st, input logic [3:0] sel,
                              input logic cin, input logic [4:0] rd,
                              input logic rw, input logic mr);
        exp_t e;
        e.alu_a = a; e.alu_b = b; e.store = st; e.sel = sel;
        e.cin = cin; e.rd = rd; e.rw = rw; e.mr = mr;
        q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".alu_a"}, ALU_A,                 e.alu_a);
            chk({tag, ".alu_b"}, ALU_B,                 e.alu_b);
            chk({tag, ".store"}, Store_Data,            e.store);
            chk({tag, ".sel"},   {28'd0, ALU_Select},   {28'd0, e.sel});
            chk({tag, ".cin"},   {31'd0, ALU_Cin},      {31'd0, e.cin});
            chk({tag, ".rd"},    {27'd0, EX_Rd},        {27'd0, e.rd});
            chk({tag, ".rw"},    {31'd0, EX_Reg_Write}, {31'd0, e.rw});
            chk({tag, ".mr"},    {31'd0, EX_Mem_Read},  {31'd0, e.mr});
        end
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d,
                            input logic [DW-1:0] imm, input logic [3:0] sel,
                            input logic cin, input logic use_imm,
                            input logic rw, input logic mr);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
        ID_Rs_Data = rs_d; ID_Rt_Data = rt_d; ID_Imm = imm;
        ID_Select = sel; ID_Cin = cin; ID_Use_Imm = use_imm;
        ID_Reg_Write = rw; ID_Mem_Read = mr;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive_id(5'd0, 5'd0, 5'd0, '0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        MEM_Reg_Write = 1'b0; MEM_Rd = '0; MEM_Result = '0;
        WB_Reg_Write  = 1'b0; WB_Rd  = '0; WB_Result  = '0;

        // reset state
        #2;
        expect_out('0, '0, '0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_out("reset");
        chk("reset.load_use", {31'd0, Load_Use}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // MEM/WB priority on A
        drive_id(5'd3, 5'd5, 5'd7, 32'h10, 32'h20, 32'h0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        MEM_Reg_Write = 1'b1; MEM_Rd = 5'd3; MEM_Result = 32'h55;
        WB_Reg_Write  = 1'b1; WB_Rd  = 5'd3; WB_Result  = 32'h66;
        expect_out(32'h55, 32'h20, 32'h20, 4'h2, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        check_out("fwd_mem");
        chk("fwd_mem.load_use", {31'd0, Load_Use}, 32'd0);
        MEM_Reg_Write = 1'b0;
        expect_out(32'h66, 32'h20, 32'h20, 4'h2, 1'b0, 5'd7, 1'b1, 1'b0);
        #1 check_out("fwd_wb");
        WB_Reg_Write = 1'b0;
        expect_out(32'h10, 32'h20, 32'h20, 4'h2, 1'b0, 5'd7, 1'b1, 1'b0);
        #1 check_out("fwd_none");

        // load-use hazard: one bubble, then the dependent instruction
        drive_id(5'd1, 5'd2, 5'd4, 32'h100, 32'h200, 32'h8, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_out(32'h100, 32'h8, 32'h200, 4'h0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        check_out("load");
        drive_id(5'd9, 5'd4, 5'd6, 32'h30, 32'h40, 32'h0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("lu.asserted", {31'd0, Load_Use}, 32'd1);
        expect_out('0, '0, '0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_out("lu.bubble");
        chk("lu.bubble.load_use", {31'd0, Load_Use}, 32'd0);
        expect_out(32'h30, 32'h40, 32'h40, 4'h3, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        check_out("lu.after");

        // load to r0 never raises the hazard
        drive_id(5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_out(32'h1, 32'h2, 32'h2, 4'h0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        check_out("load_r0");
        drive_id(5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("load_r0.load_use", {31'd0, Load_Use}, 32'd0);

        // immediate B with forwarded store data, EX/MEM over MEM/WB
        drive_id(5'd2, 5'd8, 5'd9, 32'h11, 32'h22, 32'hFFFF_FFFC, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
        MEM_Reg_Write = 1'b1; MEM_Rd = 5'd8; MEM_Result = 32'hABCD;
        WB_Reg_Write  = 1'b1; WB_Rd  = 5'd8; WB_Result  = 32'h1234;
        expect_out(32'h11, 32'hFFFF_FFFC, 32'hABCD, 4'h5, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        check_out("imm_fwd");
        MEM_Reg_Write = 1'b0;
        expect_out(32'h11, 32'hFFFF_FFFC, 32'h1234, 4'h5, 1'b1, 5'd9, 1'b1, 1'b0);
        #1 check_out("imm_fwd_wb");
        WB_Reg_Write = 1'b0;

        // stall holds for three cycles while ID inputs change
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(5'(i + 10), 5'(i + 20), 5'(i + 11), 32'(i), 32'(i + 1), 32'(i + 2),
                     4'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1);
            expect_out(32'h11, 32'hFFFF_FFFC, 32'h22, 4'h5, 1'b1, 5'd9, 1'b1, 1'b0);
            tick();
            check_out("stall");
        end
        Flush = 1'b1;
        expect_out('0, '0, '0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_out("stall_flush");
        Stall = 1'b0; Flush = 1'b0;

        // flush alone squashes a valid instruction
        drive_id(5'd6, 5'd7, 5'd10, 32'h77, 32'h88, 32'h0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out(32'h77, 32'h88, 32'h88, 4'h7, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        check_out("pre_flush");
        Flush = 1'b1;
        expect_out('0, '0, '0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_out("flush");
        Flush = 1'b0;

        // asynchronous reset mid-cycle, r0 writers never forward
        expect_out(32'h77, 32'h88, 32'h88, 4'h7, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        check_out("pre_rst");
        MEM_Reg_Write = 1'b1; MEM_Rd = 5'd0; MEM_Result = 32'hDEAD;
        WB_Reg_Write  = 1'b1; WB_Rd  = 5'd0; WB_Result  = 32'hBEEF;
        #2 Rst = 1'b1;
        expect_out('0, '0, '0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 check_out("async_rst");
        chk("async_rst.load_use", {31'd0, Load_Use}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        drive_id(5'd0, 5'd0, 5'd1, 32'h5, 32'h6, 32'h0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out(32'h5, 32'h6, 32'h6, 4'h1, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        check_out("r0_nofwd");

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
